io_intr_ctrl: RTL

//  Interrupt controller directly upstream of the CPU interrupt input and beside the IO memory on the data bus.

---
 rtl/io_intr_ctrl_pkg.sv | 29 ++
 rtl/io_intr_prio_enc.sv | 28 ++
 rtl/io_intr_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_intr_ctrl_pkg.sv
// Package: io_intr_ctrl_pkg
// Purpose: shared definitions for the IO interrupt controller.
//   - state_t   : handshake FSM encoding. The values are visible to software
//                 through STAT[1:0], so they must not be renumbered.
//   - REG_*     : register offsets as decoded from Addr[3:2]
//   - count_ones16 : population count, used to total up lost edges
package io_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VECT = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  function automatic logic [4:0] count_ones16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/io_intr_prio_enc.sv
// Module: io_intr_prio_enc
// Purpose: combinational lowest-index priority encoder.
// Ports:
//   req  in  N     request vector
//   any  out 1     at least one request bit is set
//   id   out ID_W  index of the lowest set request bit (0 when none is set)
module io_intr_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 4
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [ID_W-1:0] id
);

  // The loop scans from the top index down, so the lowest set bit is the
  // last one written and therefore wins.
  always_comb begin
    any = |req;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_intr_ctrl.sv
// Module: io_intr_ctrl
// Purpose: interrupt controller that sits between the peripherals and the
//   CPU interrupt input.
//   - Rising edges on the src lines are latched into PEND.
//   - MASK selects which pending sources may interrupt the CPU.
//   - The lowest-numbered pending, enabled source is served through an
//     intr/int_ack handshake.
//   - Software reads and clears the registers over the dm_* data bus.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   src      in   NUM_SRC peripheral request lines (synchronous to clk)
//   dm_cs    in   chip select
//   dm_rd    in   read strobe
//   dm_wr    in   write strobe
//   Addr     in   byte address; only Addr[3:2] is decoded
//   D_In     in   write data
//   D_Out    out  read data (combinational; 0 when not reading)
//   intr     out  registered interrupt request to the CPU
//   int_ack  in   interrupt acknowledge from the CPU
// Configuration:
//   IO_INTR_TIMEOUT_EN - when defined, a request that is not acknowledged
//     within ACK_TIMEOUT cycles is withdrawn. Its pend bit is kept and
//     STAT[2] is set as a sticky flag.
module io_intr_ctrl
  import io_intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               dm_cs,
  input  logic               dm_rd,
  input  logic               dm_wr,
  input  logic [31:0]        Addr,
  input  logic [31:0]        D_In,
  output logic [31:0]        D_Out,
  output logic               intr,
  input  logic               int_ack
);

`ifdef IO_INTR_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] w1c_bits;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] lost_hits;
  logic [8:0]         lost_sum;
  logic [7:0]         lost;
  logic               vect_valid;
  logic [ID_W-1:0]    vect_id;
  logic               to_sticky;
  logic               to_set;
  logic               timeout_hit;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    id;
  logic [ID_W-1:0]    id_nxt;
  logic [7:0]         req_cnt;
  logic [7:0]         req_cnt_nxt;

  logic               enc_any;
  logic [ID_W-1:0]    enc_id;

  logic               wr_en;
  logic               rd_en;
  logic [1:0]         sel;
  logic               unused_ok;

  assign wr_en = dm_cs & dm_wr;
  assign rd_en = dm_cs & dm_rd;
  assign sel   = Addr[3:2];

  assign unused_ok = ^{Addr[31:4], Addr[1:0], D_In[31:NUM_SRC]};

  assign src_rise  = src & ~src_q;
  assign w1c_bits  = (wr_en && sel == REG_PEND) ? D_In[NUM_SRC-1:0] : '0;
  assign ack_clr   = (state == ST_ACK) ? (NUM_SRC'(1) << id) : '0;
  assign lost_hits = src_rise & pend;
  assign lost_sum  = 9'(lost) + 9'(count_ones16(16'(lost_hits)));

  assign timeout_hit = TIMEOUT_ON && (req_cnt == TIMEOUT_LAST);

  io_intr_prio_enc #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req (pend & mask),
    .any (enc_any),
    .id  (enc_id)
  );

  // Pending bits are cleared first and set second, so a new edge always
  // beats a software W1C or the ACK clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      src_q <= src;
      pend  <= (pend & ~(w1c_bits | ack_clr)) | src_rise;
      if (wr_en && sel == REG_MASK) begin
        mask <= D_In[NUM_SRC-1:0];
      end
    end
  end

  // Lost counter: an edge that lands on an already-pending source is
  // counted. Several such edges in one cycle each count. The counter
  // saturates at 255. Any STAT write clears it and takes precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lost <= '0;
    end else if (wr_en && sel == REG_STAT) begin
      lost <= '0;
    end else if (lost_sum > 9'd255) begin
      lost <= 8'hFF;
    end else begin
      lost <= lost_sum[7:0];
    end
  end

  // VECT latches the served id on the ACK cycle. That update wins over a
  // read-to-clear in the same cycle, so a fresh vector is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vect_valid <= 1'b0;
      vect_id    <= '0;
    end else if (state == ST_ACK) begin
      vect_valid <= 1'b1;
      vect_id    <= id;
    end else if (rd_en && sel == REG_VECT) begin
      vect_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_sticky <= 1'b0;
    end else if (to_set) begin
      to_sticky <= 1'b1;
    end else if (wr_en && sel == REG_STAT) begin
      to_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      id      <= '0;
      req_cnt <= '0;
      intr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      id      <= id_nxt;
      req_cnt <= req_cnt_nxt;
      intr    <= (state_nxt == ST_REQ);
    end
  end

  // The id is captured only when leaving IDLE. It then stays frozen through
  // REQ and ACK, even if software masks or clears that source in between.
  always_comb begin
    state_nxt   = state;
    id_nxt      = id;
    req_cnt_nxt = req_cnt;
    to_set      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enc_any) begin
          id_nxt      = enc_id;
          req_cnt_nxt = '0;
          state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_nxt = ST_ACK;
        end else if (timeout_hit) begin
          to_set    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          req_cnt_nxt = req_cnt + 8'd1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    D_Out = '0;
    if (rd_en) begin
      case (sel)
        REG_PEND: D_Out[NUM_SRC-1:0] = pend;
        REG_MASK: D_Out[NUM_SRC-1:0] = mask;
        REG_VECT: begin
          D_Out[31]        = vect_valid;
          D_Out[ID_W-1:0]  = vect_id;
        end
        REG_STAT: begin
          D_Out[15:8] = lost;
          D_Out[2]    = to_sticky;
          D_Out[1:0]  = state;
        end
        default: D_Out = '0;
      endcase
    end
  end

endmodule
